// File: rtl/load_unit_pkg.sv
// Shared definitions for the load/store path: funct3 size codes, load FSM states
// and the request legality check.
package load_unit_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // True when the request must be answered with an error and never reach memory.
  function automatic logic load_bad(input logic [2:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      LB, LBU: bad = 1'b0;
      LH, LHU: bad = offset[0];
      LW:      bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Combinational byte/halfword selection from a read word, with sign or zero
// extension chosen by the load size.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign bytes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = bytes[offset];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    data     = '0;
    case (size)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0, half_sel};
      LW:      data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: validates the request, issues one word read,
// waits with a timeout, then extracts and holds the response until accepted.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        m_req,
  output logic [4:0]  m_addr,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state, state_next;
  logic [1:0]      off_reg;
  logic [2:0]      size_reg;
  logic [CW-1:0]   cnt_reg;
  logic [31:0]     ext_data;
  logic            bad;
  logic            expire;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^ld_addr[31:7];
  assign bad    = load_bad(ld_size, ld_addr[1:0]);
  // Last permitted wait cycle; m_rvalid in this cycle still takes priority.
  assign expire = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  load_extract u_extract (
    .rdata  (m_rdata),
    .offset (off_reg),
    .size   (size_reg),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    m_req      = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) state_next = bad ? RESP : REQ;
      end
      REQ: begin
        m_req = 1'b1;
        if (m_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (m_rvalid || expire) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_reg  <= '0;
      size_reg <= '0;
      m_addr   <= '0;
      cnt_reg  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == IDLE && ld_valid) begin
        off_reg  <= ld_addr[1:0];
        size_reg <= ld_size;
        m_addr   <= ld_addr[6:2];
        if (bad) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state == REQ && m_gnt) cnt_reg <= '0;
      if (state == WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (m_rvalid) begin
          rsp_data <= ext_data;
          rsp_err  <= 1'b0;
        end else if (expire) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

endmodule
